// File: rtl/mont_encode.sv
// Standard-form to Montgomery-form converter: x*2^SIZE mod p by a bit-serial Horner pass,
// one modular doubling per cycle over 2*SIZE cycles.
module mont_encode #(
  parameter int SIZE = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [SIZE-1:0] i_x,
  input  logic [SIZE-1:0] i_p,
  output logic            o_busy,
  output logic            o_done,
  output logic [SIZE-1:0] o_result,
  output logic            o_err
);

  // state  | meaning
  // IDLE   | waiting for i_start; operands latched on acceptance
  // RUN    | 2*SIZE modular doublings, x fed MSB first then zeros
  // DONE   | result registered, o_done pulses in the following cycle

  localparam int CW = $clog2(2*SIZE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [SIZE-1:0] r_x, r_p, r_acc, r_result;
  logic            r_done, r_err;

  logic            w_bad, w_last, w_ge;
  logic [SIZE:0]   w_t;
  logic [SIZE-1:0] w_acc_nxt;

  assign w_bad  = ~i_p[0] | (i_p < SIZE'(3));
  assign w_last = (r_cnt == CW'(2*SIZE-1));

  // acc < p keeps t below 2p, so a single conditional subtract reduces it
  assign w_t       = {r_acc, 1'b0} + (SIZE+1)'(r_x[SIZE-1]);
  assign w_ge      = (w_t >= {1'b0, r_p});
  assign w_acc_nxt = SIZE'(w_ge ? (w_t - {1'b0, r_p}) : w_t);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = w_bad ? S_DONE : S_RUN;
      S_RUN:   if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_x      <= '0;
      r_p      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x   <= i_x;
            r_p   <= i_p;
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= w_bad;
          end
        end
        S_RUN: begin
          // shifting x left supplies zeros once its SIZE bits are consumed
          r_acc <= w_acc_nxt;
          r_x   <= {r_x[SIZE-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_result <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state == S_RUN);
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_err    = r_err;

endmodule
